thread_regfile: RTL and testbench

- Per-thread register file, directly upstream of the per-thread ALU and LSU; also consumes their results at writeback.
- Holds 16 x 8-bit registers: R0-R12 general purpose, R13-R15 read-only special registers (blockIdx, blockDim, threadIdx).
- Latches the rs/rt operands during REQUEST and writes back the ALU, LSU or immediate result during UPDATE.
- One instance per thread slot in each core.

---
 rtl/gpu_pkg.sv | 30 +++
 rtl/thread_regfile_if.sv | 41 ++++
 rtl/thread_regfile.sv | 80 ++++++++
 tb/tb_thread_regfile.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: core FSM encodings, writeback source select,
// special register indices and the default datapath width.
package gpu_pkg;

    localparam int unsigned DATA_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_e;

    typedef enum logic [1:0] {
        MUX_ALU  = 2'b00,
        MUX_LSU  = 2'b01,
        MUX_IMM  = 2'b10,
        MUX_RSVD = 2'b11
    } reg_input_mux_e;

    // Read-only special registers occupy the top of the register file.
    localparam logic [3:0] R_BLOCK_IDX  = 4'd13;
    localparam logic [3:0] R_BLOCK_DIM  = 4'd14;
    localparam logic [3:0] R_THREAD_IDX = 4'd15;

endpackage

// File: rtl/thread_regfile_if.sv
// Decoded-instruction, execution-result and operand signals between the
// core and one thread's register file.
interface thread_regfile_if
    import gpu_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
);
    logic                 enable;
    logic [DATA_BITS-1:0] block_id;
    logic [2:0]           core_state;
    logic [3:0]           decoded_rd_address;
    logic [3:0]           decoded_rs_address;
    logic [3:0]           decoded_rt_address;
    logic                 decoded_reg_write_enable;
    logic [1:0]           decoded_reg_input_mux;
    logic [DATA_BITS-1:0] decoded_immediate;
    logic [DATA_BITS-1:0] alu_out;
    logic [DATA_BITS-1:0] lsu_out;
    logic [DATA_BITS-1:0] rs;
    logic [DATA_BITS-1:0] rt;
    logic                 ro_write_err;

    // Core side: drives control and results, receives operands.
    modport master (
        output enable, block_id, core_state,
        output decoded_rd_address, decoded_rs_address, decoded_rt_address,
        output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        output alu_out, lsu_out,
        input  rs, rt, ro_write_err
    );

    // Register file side.
    modport slave (
        input  enable, block_id, core_state,
        input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
        input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        input  alu_out, lsu_out,
        output rs, rt, ro_write_err
    );

endinterface

// File: rtl/thread_regfile.sv
// Per-thread register file: 13 general registers plus read-only blockIdx,
// blockDim and threadIdx. Operands are latched in REQUEST, results written
// back in UPDATE.
module thread_regfile
    import gpu_pkg::*;
#(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned THREAD_ID         = 0,
    parameter int unsigned DATA_BITS         = DATA_BITS_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    thread_regfile_if.slave bus
);

    localparam int unsigned NUM_REGS = 16;

    logic [DATA_BITS-1:0] r_regs [NUM_REGS];
    logic [DATA_BITS-1:0] r_rs;
    logic [DATA_BITS-1:0] r_rt;
    logic                 r_err;

    logic                 w_wr_req;
    logic                 w_rd_ro;
    logic                 w_mux_rsvd;
    logic                 w_wr_ok;
    logic                 w_wr_bad;
    logic [DATA_BITS-1:0] w_wr_data;

    assign w_wr_req   = bus.enable && (bus.core_state == CORE_UPDATE)
                        && bus.decoded_reg_write_enable;
    assign w_rd_ro    = bus.decoded_rd_address >= R_BLOCK_IDX;
    assign w_mux_rsvd = bus.decoded_reg_input_mux == MUX_RSVD;
    assign w_wr_ok    = w_wr_req && !w_rd_ro && !w_mux_rsvd;
    assign w_wr_bad   = w_wr_req && (w_rd_ro || w_mux_rsvd);

    // Select the writeback source.
    always_comb begin
        w_wr_data = '0;
        case (bus.decoded_reg_input_mux)
            MUX_ALU: w_wr_data = bus.alu_out;
            MUX_LSU: w_wr_data = bus.lsu_out;
            MUX_IMM: w_wr_data = bus.decoded_immediate;
            default: w_wr_data = '0;
        endcase
    end

    // Register array, operand latch and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(R_BLOCK_DIM); i++) begin
                r_regs[i] <= '0;
            end
            r_regs[R_BLOCK_DIM]  <= DATA_BITS'(THREADS_PER_BLOCK);
            r_regs[R_THREAD_IDX] <= DATA_BITS'(THREAD_ID);
            r_rs                 <= '0;
            r_rt                 <= '0;
            r_err                <= 1'b0;
        end else if (bus.enable) begin
            // blockIdx tracks the core every active cycle; R14/R15 are never
            // written outside reset.
            r_regs[R_BLOCK_IDX] <= bus.block_id;
            if (w_wr_ok) begin
                r_regs[bus.decoded_rd_address] <= w_wr_data;
            end
            if (w_wr_bad) begin
                r_err <= 1'b1;
            end
            if (bus.core_state == CORE_REQUEST) begin
                r_rs <= r_regs[bus.decoded_rs_address];
                r_rt <= r_regs[bus.decoded_rt_address];
            end
        end
    end

    assign bus.rs           = r_rs;
    assign bus.rt           = r_rt;
    assign bus.ro_write_err = r_err;

endmodule

// File: tb/tb_thread_regfile.sv
// Scoreboard bench for thread_regfile: the driver pushes the expected
// operand/flag state for observed cycles, a negedge monitor pops and compares.
module tb_thread_regfile;
    import gpu_pkg::*;

    typedef struct packed {
        logic [7:0] rs;
        logic [7:0] rt;
        logic       err;
    } exp_t;

    logic clk;
    logic reset;
    logic obs;
    logic obs_q;
    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    thread_regfile_if #(.DATA_BITS(8)) bus ();

    thread_regfile #(
        .THREADS_PER_BLOCK(4),
        .THREAD_ID        (2),
        .DATA_BITS        (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs for a stimulus cycle appear after the edge that consumed it.
    always @(posedge clk) obs_q <= obs;

    always @(negedge clk) begin
        if (obs_q) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_underflow: got output with no expectation");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks += 3;
                if (bus.rs !== e.rs) begin
                    n_errors++;
                    $display("FAIL rs: got %02h expected %02h at %0t", bus.rs, e.rs, $time);
                end
                if (bus.rt !== e.rt) begin
                    n_errors++;
                    $display("FAIL rt: got %02h expected %02h at %0t", bus.rt, e.rt, $time);
                end
                if (bus.ro_write_err !== e.err) begin
                    n_errors++;
                    $display("FAIL ro_write_err: got %0b expected %0b at %0t",
                             bus.ro_write_err, e.err, $time);
                end
            end
        end
    end

    // Apply the current inputs for one cycle; optionally record what the
    // outputs must be after that edge.
    task automatic step(input logic do_obs, input logic [7:0] ers, input logic [7:0] ert,
                        input logic eerr);
        exp_t e;
        if (do_obs) begin
            e.rs  = ers;
            e.rt  = ert;
            e.err = eerr;
            exp_q.push_back(e);
        end
        obs = do_obs;
        @(posedge clk);
        #1;
        obs = 1'b0;
        bus.core_state               = CORE_IDLE;
        bus.decoded_reg_write_enable = 1'b0;
    endtask

    task automatic req(input logic [3:0] a_rs, input logic [3:0] a_rt, input logic [7:0] ers,
                       input logic [7:0] ert, input logic eerr);
        bus.core_state         = CORE_REQUEST;
        bus.decoded_rs_address = a_rs;
        bus.decoded_rt_address = a_rt;
        step(1'b1, ers, ert, eerr);
    endtask

    task automatic upd(input logic [2:0] st, input logic [3:0] rd, input logic [1:0] mux,
                       input logic [7:0] val);
        bus.core_state               = st;
        bus.decoded_rd_address       = rd;
        bus.decoded_reg_write_enable = 1'b1;
        bus.decoded_reg_input_mux    = mux;
        bus.decoded_immediate        = (mux == MUX_IMM) ? val : 8'hE1;
        bus.alu_out                  = (mux == MUX_ALU) ? val : 8'hE2;
        bus.lsu_out                  = (mux == MUX_LSU) ? val : 8'hE3;
        step(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        obs      = 1'b0;
        reset    = 1'b1;
        bus.enable                   = 1'b1;
        bus.block_id                 = 8'd0;
        bus.core_state               = CORE_IDLE;
        bus.decoded_rd_address       = 4'd0;
        bus.decoded_rs_address       = 4'd0;
        bus.decoded_rt_address       = 4'd0;
        bus.decoded_reg_write_enable = 1'b0;
        bus.decoded_reg_input_mux    = MUX_ALU;
        bus.decoded_immediate        = 8'd0;
        bus.alu_out                  = 8'd0;
        bus.lsu_out                  = 8'd0;

        // Reset state
        step(1'b0, '0, '0, 1'b0);
        step(1'b1, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;

        // Special registers and R0
        req(4'd14, 4'd15, 8'h04, 8'h02, 1'b0);
        req(4'd0,  4'd13, 8'h00, 8'h00, 1'b0);

        // blockIdx mirror
        bus.block_id = 8'd7;
        step(1'b0, '0, '0, 1'b0);
        req(4'd13, 4'd0, 8'h07, 8'h00, 1'b0);

        // Disabled slot holds everything, including R13
        bus.enable   = 1'b0;
        bus.block_id = 8'd9;
        req(4'd14, 4'd15, 8'h07, 8'h00, 1'b0);
        upd(CORE_UPDATE, 4'd6, MUX_IMM, 8'h66);
        bus.enable = 1'b1;
        req(4'd13, 4'd13, 8'h07, 8'h07, 1'b0);
        req(4'd13, 4'd6,  8'h09, 8'h00, 1'b0);

        // Non-REQUEST states do not disturb the operand latch
        bus.core_state         = CORE_DECODE;
        bus.decoded_rs_address = 4'd14;
        bus.decoded_rt_address = 4'd15;
        step(1'b1, 8'h09, 8'h00, 1'b0);

        // Writeback sources
        upd(CORE_UPDATE, 4'd3, MUX_IMM, 8'hA5);
        req(4'd3, 4'd14, 8'hA5, 8'h04, 1'b0);
        upd(CORE_UPDATE, 4'd4,  MUX_ALU, 8'h3C);
        upd(CORE_UPDATE, 4'd12, MUX_LSU, 8'hFF);
        req(4'd4, 4'd12, 8'h3C, 8'hFF, 1'b0);

        // Write to read-only R15 is dropped and flagged
        upd(CORE_UPDATE, 4'd15, MUX_IMM, 8'h11);
        req(4'd15, 4'd13, 8'h02, 8'h09, 1'b1);

        // Writes only land in UPDATE; flag stays sticky meanwhile
        upd(CORE_EXECUTE, 4'd5, MUX_IMM, 8'h5A);
        upd(CORE_WAIT,    4'd5, MUX_IMM, 8'h5A);
        bus.decoded_reg_write_enable = 1'b1;
        bus.decoded_rd_address       = 4'd5;
        req(4'd5, 4'd5, 8'h00, 8'h00, 1'b1);
        req(4'd5, 4'd15, 8'h00, 8'h02, 1'b1);
        upd(CORE_UPDATE, 4'd5, MUX_IMM, 8'h5A);
        req(4'd5, 4'd3, 8'h5A, 8'hA5, 1'b1);

        // Reset during UPDATE discards the pending write
        upd(CORE_UPDATE, 4'd6, MUX_IMM, 8'h55);
        req(4'd6, 4'd6, 8'h55, 8'h55, 1'b1);
        reset                        = 1'b1;
        bus.core_state               = CORE_UPDATE;
        bus.decoded_rd_address       = 4'd6;
        bus.decoded_reg_write_enable = 1'b1;
        bus.decoded_reg_input_mux    = MUX_IMM;
        bus.decoded_immediate        = 8'h77;
        step(1'b1, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        req(4'd6,  4'd14, 8'h00, 8'h04, 1'b0);
        req(4'd15, 4'd3,  8'h02, 8'h00, 1'b0);

        // Reserved mux value: no write, flag set
        upd(CORE_UPDATE, 4'd1, MUX_IMM, 8'h21);
        req(4'd1, 4'd1, 8'h21, 8'h21, 1'b0);
        upd(CORE_UPDATE, 4'd1, MUX_RSVD, 8'h99);
        req(4'd1, 4'd1, 8'h21, 8'h21, 1'b1);

        // Let the monitor drain, then make sure nothing was left unchecked
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
